// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA types, default 640x480-style timing and write-field codes
//
// Purpose: common definitions for the VGA triangle rasteriser.
// Contents: rgb444_t colour type, default timing constants (counter units),
//           wr_field encodings for the triangle write port.
package vga_pkg;

  typedef logic [11:0] rgb444_t;

  localparam int H_TOTAL_D = 1586;
  localparam int H_SYNC_D  = 190;
  localparam int H_START_D = 285;
  localparam int H_END_D   = 1555;
  localparam int V_TOTAL_D = 526;
  localparam int V_SYNC_D  = 2;
  localparam int V_START_D = 35;
  localparam int V_END_D   = 515;

  localparam logic [1:0] FLD_P1  = 2'd0;
  localparam logic [1:0] FLD_P2  = 2'd1;
  localparam logic [1:0] FLD_P3  = 2'd2;
  localparam logic [1:0] FLD_COL = 2'd3;

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel/line counters, raw sync/visible flags and frame commit strobe
//
// Purpose: free-running raster counters for the rasteriser.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   cx, cy         : current counter position (signed, COORD_W bits)
//   commit         : high on the last clock of the frame (cx == H_TOTAL-1, cy == V_TOTAL-1)
//   hs_raw, vs_raw : undelayed active-low sync for the current counter value
//   vis_raw        : current counter value lies in the visible window
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_D,
  parameter int H_SYNC  = H_SYNC_D,
  parameter int H_START = H_START_D,
  parameter int H_END   = H_END_D,
  parameter int V_TOTAL = V_TOTAL_D,
  parameter int V_SYNC  = V_SYNC_D,
  parameter int V_START = V_START_D,
  parameter int V_END   = V_END_D,
  parameter int COORD_W = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic signed [COORD_W-1:0] cx,
  output logic signed [COORD_W-1:0] cy,
  output logic                      commit,
  output logic                      hs_raw,
  output logic                      vs_raw,
  output logic                      vis_raw
);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_SY   = COORD_W'(H_SYNC);
  localparam logic [COORD_W-1:0] H_ST   = COORD_W'(H_START);
  localparam logic [COORD_W-1:0] H_EN   = COORD_W'(H_END);
  localparam logic [COORD_W-1:0] V_SY   = COORD_W'(V_SYNC);
  localparam logic [COORD_W-1:0] V_ST   = COORD_W'(V_START);
  localparam logic [COORD_W-1:0] V_EN   = COORD_W'(V_END);

  logic [COORD_W-1:0] hcnt, vcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + COORD_W'(1);
    end else begin
      hcnt <= hcnt + COORD_W'(1);
    end
  end

  assign cx      = hcnt;
  assign cy      = vcnt;
  assign commit  = (hcnt == H_LAST) && (vcnt == V_LAST);
  assign hs_raw  = (hcnt >= H_SY);
  assign vs_raw  = (vcnt >= V_SY);
  assign vis_raw = (hcnt >= H_ST) && (hcnt < H_EN) && (vcnt >= V_ST) && (vcnt < V_EN);

endmodule

// File: rtl/vga_tri_raster.sv
// rtl/vga_tri_raster.sv - VGA triangle rasteriser with double-buffered triangle slots
//
// Purpose: drives VGA sync and per-pixel colour of the lowest-index triangle
//          covering the pixel; triangles are loaded into a shadow bank and
//          copied to the active bank on the last clock of each frame.
// Ports:
//   CLOCK_50, RST         : clock, synchronous active-high reset
//   wr_valid / wr_ready   : write handshake (ready low only on the commit cycle)
//   wr_idx, wr_field      : slot and field (P1/P2/P3 vertex or colour/enable)
//   wr_x, wr_y            : signed vertex coordinates in counter units
//   wr_color, wr_en       : slot colour (4:4:4) and enable
//   frame_start           : one-cycle pulse on the commit cycle
//   VGA_R/G/B, VGA_HS/VS  : pins, 2 clocks after the counter value they belong to
module vga_tri_raster
  import vga_pkg::*;
#(
  parameter int      H_TOTAL   = H_TOTAL_D,
  parameter int      H_SYNC    = H_SYNC_D,
  parameter int      H_START   = H_START_D,
  parameter int      H_END     = H_END_D,
  parameter int      V_TOTAL   = V_TOTAL_D,
  parameter int      V_SYNC    = V_SYNC_D,
  parameter int      V_START   = V_START_D,
  parameter int      V_END     = V_END_D,
  parameter int      NUM_TRI   = 4,
  parameter int      COORD_W   = 12,
  parameter rgb444_t BG        = 12'h000,
  parameter int      TWO_SIDED = 0,
  localparam int     IDX_W     = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1
) (
  input  logic                      CLOCK_50,
  input  logic                      RST,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [1:0]                wr_field,
  input  logic signed [COORD_W-1:0] wr_x,
  input  logic signed [COORD_W-1:0] wr_y,
  input  logic [11:0]               wr_color,
  input  logic                      wr_en,
  output logic                      frame_start,
  output logic [3:0]                VGA_R,
  output logic [3:0]                VGA_G,
  output logic [3:0]                VGA_B,
  output logic                      VGA_HS,
  output logic                      VGA_VS
);

  // Edge products need 2*(COORD_W+1) bits; one more for the difference.
  localparam int PW = 2 * COORD_W + 3;

  function automatic logic signed [COORD_W:0] sdiff(input logic signed [COORD_W-1:0] a,
                                                    input logic signed [COORD_W-1:0] b);
    return (COORD_W + 1)'(a) - (COORD_W + 1)'(b);
  endfunction

  logic signed [COORD_W-1:0] cx, cy;
  logic commit, hs_raw, vs_raw, vis_raw;

  vga_timing #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_START(H_START), .H_END(H_END),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_START(V_START), .V_END(V_END),
    .COORD_W(COORD_W)
  ) u_timing (
    .clk     (CLOCK_50),
    .rst     (RST),
    .cx      (cx),
    .cy      (cy),
    .commit  (commit),
    .hs_raw  (hs_raw),
    .vs_raw  (vs_raw),
    .vis_raw (vis_raw)
  );

  // Reset wins over commit, so the strobe and the stall are masked while RST is high.
  assign wr_ready    = RST | ~commit;
  assign frame_start = commit & ~RST;

  // Triangle banks: writes land in sh_*, the raster reads only act_*.
  logic signed [COORD_W-1:0] sh_x  [NUM_TRI][3];
  logic signed [COORD_W-1:0] sh_y  [NUM_TRI][3];
  logic signed [COORD_W-1:0] act_x [NUM_TRI][3];
  logic signed [COORD_W-1:0] act_y [NUM_TRI][3];
  rgb444_t                   sh_col  [NUM_TRI];
  rgb444_t                   act_col [NUM_TRI];
  logic                      sh_en   [NUM_TRI];
  logic                      act_en  [NUM_TRI];

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      for (int t = 0; t < NUM_TRI; t++) begin
        sh_col[t]  <= '0;
        act_col[t] <= '0;
        sh_en[t]   <= 1'b0;
        act_en[t]  <= 1'b0;
        for (int k = 0; k < 3; k++) begin
          sh_x[t][k]  <= '0;
          sh_y[t][k]  <= '0;
          act_x[t][k] <= '0;
          act_y[t][k] <= '0;
        end
      end
    end else begin
      if (commit) begin
        act_x   <= sh_x;
        act_y   <= sh_y;
        act_col <= sh_col;
        act_en  <= sh_en;
      end
      // wr_ready is low on the commit cycle, so copy and write never collide.
      if (wr_valid && wr_ready && (int'(wr_idx) < NUM_TRI)) begin
        case (wr_field)
          FLD_P1, FLD_P2, FLD_P3: begin
            sh_x[wr_idx][wr_field] <= wr_x;
            sh_y[wr_idx][wr_field] <= wr_y;
          end
          FLD_COL: begin
            sh_col[wr_idx] <= wr_color;
            sh_en[wr_idx]  <= wr_en;
          end
        endcase
      end
    end
  end

  // Stage 1: shared sync/visible flags.
  logic s1_vis, s1_hs, s1_vs;

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      s1_vis <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
    end else begin
      s1_vis <= vis_raw;
      s1_hs  <= hs_raw;
      s1_vs  <= vs_raw;
    end
  end

  logic    lane_in  [NUM_TRI];
  rgb444_t lane_col [NUM_TRI];

  for (genvar t = 0; t < NUM_TRI; t++) begin : g_lane
    logic [2:0] nonpos, nonneg;
    rgb444_t    col_q;
    logic       en_q;

    // Colour/enable travel with the differences so a pixel never mixes banks.
    always_ff @(posedge CLOCK_50) begin
      if (RST) begin
        col_q <= '0;
        en_q  <= 1'b0;
      end else begin
        col_q <= act_col[t];
        en_q  <= act_en[t];
      end
    end

    for (genvar k = 0; k < 3; k++) begin : g_edge
      localparam int KB = (k + 1) % 3;
      logic signed [COORD_W:0] dbx, dyc, dxc, dby;
      logic signed [PW-1:0]    e;

      always_ff @(posedge CLOCK_50) begin
        if (RST) begin
          dbx <= '0;
          dyc <= '0;
          dxc <= '0;
          dby <= '0;
        end else begin
          dbx <= sdiff(act_x[t][KB], act_x[t][k]);
          dyc <= sdiff(cy, act_y[t][k]);
          dxc <= sdiff(cx, act_x[t][k]);
          dby <= sdiff(act_y[t][KB], act_y[t][k]);
        end
      end

      assign e         = PW'(dbx) * PW'(dyc) - PW'(dxc) * PW'(dby);
      assign nonpos[k] = e[PW-1] | (e == '0);
      assign nonneg[k] = ~e[PW-1];
    end

    // A zero-area triangle has edge values summing to zero, so the sign test
    // alone already limits it to the pixels where every edge value is 0.
    assign lane_in[t]  = en_q & ((&nonpos) | ((TWO_SIDED != 0) & (&nonneg)));
    assign lane_col[t] = col_q;
  end

  // Stage 2: priority select (lowest index wins) and output registers.
  rgb444_t pix;

  always_comb begin
    pix = BG;
    for (int t = NUM_TRI - 1; t >= 0; t--) begin
      if (lane_in[t]) pix = lane_col[t];
    end
    if (!s1_vis) pix = '0;
  end

  rgb444_t rgb_q;
  logic    hs_q, vs_q;

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      rgb_q <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      rgb_q <= pix;
      hs_q  <= s1_hs;
      vs_q  <= s1_vs;
    end
  end

  assign VGA_R  = rgb_q[11:8];
  assign VGA_G  = rgb_q[7:4];
  assign VGA_B  = rgb_q[3:0];
  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;

endmodule

// File: tb/tb_vga_tri_raster.sv
// tb/tb_vga_tri_raster.sv - directed bench for vga_tri_raster (one-sided and two-sided instances)
module tb_vga_tri_raster;
  import vga_pkg::*;

  localparam int HT = 72, HSW = 6, HST = 10, HEN = 70;
  localparam int VT = 40, VSW = 2, VST = 4, VEN = 38;
  localparam int NT = 3, CW = 12;
  localparam int FRAME = HT * VT;

  logic CLOCK_50 = 1'b0;
  logic RST = 1'b1;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic                 wr_valid = 1'b0;
  logic [1:0]           wr_idx = '0;
  logic [1:0]           wr_field = '0;
  logic signed [CW-1:0] wr_x = '0;
  logic signed [CW-1:0] wr_y = '0;
  logic [11:0]          wr_color = '0;
  logic                 wr_en = 1'b0;

  logic       wr_ready_a, frame_start_a, hs_a, vs_a;
  logic [3:0] r_a, g_a, b_a;
  logic       wr_ready_b, frame_start_b, hs_b, vs_b;
  logic [3:0] r_b, g_b, b_b;
  logic [11:0] rgb_a, rgb_b;
  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};

  vga_tri_raster #(
    .H_TOTAL(HT), .H_SYNC(HSW), .H_START(HST), .H_END(HEN),
    .V_TOTAL(VT), .V_SYNC(VSW), .V_START(VST), .V_END(VEN),
    .NUM_TRI(NT), .COORD_W(CW), .BG(12'h123), .TWO_SIDED(0)
  ) u_dut_a (
    .CLOCK_50(CLOCK_50), .RST(RST), .wr_valid(wr_valid), .wr_ready(wr_ready_a),
    .wr_idx(wr_idx), .wr_field(wr_field), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .wr_en(wr_en), .frame_start(frame_start_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_HS(hs_a), .VGA_VS(vs_a)
  );

  vga_tri_raster #(
    .H_TOTAL(HT), .H_SYNC(HSW), .H_START(HST), .H_END(HEN),
    .V_TOTAL(VT), .V_SYNC(VSW), .V_START(VST), .V_END(VEN),
    .NUM_TRI(NT), .COORD_W(CW), .BG(12'h000), .TWO_SIDED(1)
  ) u_dut_b (
    .CLOCK_50(CLOCK_50), .RST(RST), .wr_valid(wr_valid), .wr_ready(wr_ready_b),
    .wr_idx(wr_idx), .wr_field(wr_field), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .wr_en(wr_en), .frame_start(frame_start_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_HS(hs_b), .VGA_VS(vs_b)
  );

  // Raster position as defined by the counter rules.
  int mcx = 0, mcy = 0;
  always @(posedge CLOCK_50) begin
    if (RST) begin
      mcx <= 0;
      mcy <= 0;
    end else if (mcx == HT - 1) begin
      mcx <= 0;
      mcy <= (mcy == VT - 1) ? 0 : mcy + 1;
    end else begin
      mcx <= mcx + 1;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_at(input int x, input int y);
    int n = 0;
    while (!(mcx == x && mcy == y) && n < 2 * FRAME) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 2 * FRAME) check_eq("wait_pos", 32'(mcx * 1000 + mcy), 32'(x * 1000 + y));
  endtask

  task automatic check_pix(input string tag, input int x, input int y,
                           input logic [11:0] ea, input logic [11:0] eb);
    wait_at(x, y);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check_eq({tag, "_a"}, 32'(rgb_a), 32'(ea));
    check_eq({tag, "_b"}, 32'(rgb_b), 32'(eb));
  endtask

  task automatic do_write(input int idx, input logic [1:0] fld, input int x, input int y,
                          input logic [11:0] col, input logic en);
    int n = 0;
    wr_valid = 1'b1;
    wr_idx   = 2'(idx);
    wr_field = fld;
    wr_x     = CW'(x);
    wr_y     = CW'(y);
    wr_color = col;
    wr_en    = en;
    while (!wr_ready_a && n < 4) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 4) check_eq("wr_ready_stuck", 32'(wr_ready_a), 32'd1);
    @(negedge CLOCK_50);
    wr_valid = 1'b0;
  endtask

  task automatic load_tri(input int idx, input int x1, input int y1, input int x2, input int y2,
                          input int x3, input int y3, input logic [11:0] col, input logic en);
    do_write(idx, FLD_P1, x1, y1, 12'h000, 1'b0);
    do_write(idx, FLD_P2, x2, y2, 12'h000, 1'b0);
    do_write(idx, FLD_P3, x3, y3, 12'h000, 1'b0);
    do_write(idx, FLD_COL, 0, 0, col, en);
  endtask

  initial begin
    int n, lowc, cnt_bg, cnt_zero, cnt_nz;
    logic prev;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check_eq("rst_rgb", 32'(rgb_a), 32'd0);
    check_eq("rst_hs", 32'(hs_a), 32'd0);
    check_eq("rst_vs", 32'(vs_a), 32'd0);
    check_eq("rst_ready", 32'(wr_ready_a), 32'd1);
    check_eq("rst_fs", 32'(frame_start_a), 32'd0);
    RST = 1'b0;
    @(negedge CLOCK_50);
    check_eq("hs_after_rel", 32'(hs_a), 32'd0);

    // HS rises exactly 2 cycles after the counter reaches H_SYNC
    wait_at(HSW, 5);
    @(negedge CLOCK_50);
    check_eq("hs_lat1", 32'(hs_a), 32'd0);
    @(negedge CLOCK_50);
    check_eq("hs_lat2", 32'(hs_a), 32'd1);

    // HS period and low width
    n = 0; lowc = 0; prev = 1'b1;
    while (n < 4 * HT) begin
      @(negedge CLOCK_50);
      n++;
      if (!hs_a) lowc++;
      if (hs_a && !prev) break;
      prev = hs_a;
    end
    check_eq("hs_period", 32'(n), 32'(HT));
    check_eq("hs_low", 32'(lowc), 32'(HSW));

    // VS low width
    n = 0;
    while (vs_a && n < 2 * FRAME) begin
      @(negedge CLOCK_50);
      n++;
    end
    n = 0;
    while (!vs_a && n < 4 * HT) begin
      @(negedge CLOCK_50);
      n++;
    end
    check_eq("vs_low", 32'(n), 32'(VSW * HT));

    // Whole frame with no slots enabled
    wait_at(0, 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    cnt_bg = 0; cnt_zero = 0; cnt_nz = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (rgb_a == 12'h123) cnt_bg++;
      if (rgb_a == 12'h000) cnt_zero++;
      if (rgb_b != 12'h000) cnt_nz++;
      @(negedge CLOCK_50);
    end
    check_eq("blank_bg", 32'(cnt_bg), 32'd2040);
    check_eq("blank_zero", 32'(cnt_zero), 32'd840);
    check_eq("blank_b", 32'(cnt_nz), 32'd0);

    // Load slot 0 mid-frame; appears only after the next commit
    wait_at(0, 5);
    load_tri(0, 30, 10, 40, 30, 60, 20, 12'hCCC, 1'b1);
    check_pix("tri_cur", 40, 20, 12'h123, 12'h000);
    check_pix("tri_vtx", 30, 10, 12'hCCC, 12'hCCC);
    check_pix("tri_novis", 5, 20, 12'h000, 12'h000);
    check_pix("tri_in", 40, 20, 12'hCCC, 12'hCCC);
    check_pix("tri_out", 30, 30, 12'h123, 12'h000);

    // Reversed winding: only the two-sided instance draws it
    wait_at(0, 5);
    do_write(0, FLD_P1, 60, 20, 12'h000, 1'b0);
    do_write(0, FLD_P3, 30, 10, 12'h000, 1'b0);
    check_pix("rev_cur", 40, 20, 12'hCCC, 12'hCCC);
    wait_at(0, 0);
    check_pix("rev_next", 40, 20, 12'h123, 12'hCCC);

    // Overlap: slot 0 red over slot 2 blue; slot 3 does not exist
    wait_at(0, 5);
    load_tri(0, 30, 10, 40, 30, 60, 20, 12'hF00, 1'b1);
    load_tri(2, 30, 10, 40, 30, 60, 20, 12'h00F, 1'b1);
    load_tri(3, 0, 0, 100, 0, 0, 100, 12'hFFF, 1'b1);
    wait_at(0, 0);
    check_pix("ovl", 40, 20, 12'hF00, 12'hF00);

    // Write offered on the commit cycle is held one cycle and lands next frame
    wait_at(HT - 2, VT - 1);
    check_eq("rdy_pre", 32'(wr_ready_a), 32'd1);
    check_eq("fs_pre", 32'(frame_start_a), 32'd0);
    @(negedge CLOCK_50);
    wr_valid = 1'b1; wr_idx = 2'd0; wr_field = FLD_COL; wr_color = 12'hF00; wr_en = 1'b0;
    check_eq("rdy_commit", 32'(wr_ready_a), 32'd0);
    check_eq("fs_commit", 32'(frame_start_a), 32'd1);
    @(negedge CLOCK_50);
    check_eq("rdy_post", 32'(wr_ready_a), 32'd1);
    check_eq("fs_post", 32'(frame_start_a), 32'd0);
    @(negedge CLOCK_50);
    wr_valid = 1'b0;
    check_pix("held_cur", 40, 20, 12'hF00, 12'hF00);
    wait_at(0, 0);
    check_pix("held_next", 40, 20, 12'h00F, 12'h00F);

    // Mid-frame vertex edit to a degenerate (collinear y=20) triangle
    wait_at(0, 15);
    load_tri(2, 30, 20, 40, 20, 50, 20, 12'h00F, 1'b1);
    check_pix("tear_a", 15, 20, 12'h123, 12'h000);
    check_pix("tear_b", 40, 20, 12'h00F, 12'h00F);
    check_pix("tear_c", 40, 21, 12'h00F, 12'h00F);
    wait_at(0, 0);
    check_pix("deg_d", 40, 19, 12'h123, 12'h000);
    check_pix("deg_a", 15, 20, 12'h00F, 12'h00F);
    check_pix("deg_b", 40, 20, 12'h00F, 12'h00F);
    check_pix("deg_c", 40, 21, 12'h123, 12'h000);

    // Reset mid-frame discards both banks
    wait_at(0, 10);
    RST = 1'b1;
    @(negedge CLOCK_50);
    check_eq("rst2_rgb", 32'(rgb_a), 32'd0);
    check_eq("rst2_hs", 32'(hs_a), 32'd0);
    check_eq("rst2_vs", 32'(vs_a), 32'd0);
    check_eq("rst2_ready", 32'(wr_ready_a), 32'd1);
    check_eq("rst2_fs", 32'(frame_start_a), 32'd0);
    @(negedge CLOCK_50);
    RST = 1'b0;
    check_pix("rst_first", 40, 20, 12'h123, 12'h000);
    wait_at(0, 0);
    check_pix("rst_line", 15, 20, 12'h123, 12'h000);
    check_pix("rst_next", 40, 20, 12'h123, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_tri_raster.md
# vga_tri_raster

Parametrised VGA triangle rasteriser: it generates VGA sync and, per pixel, evaluates the three edge functions of up to NUM_TRI triangles, driving the colour of the lowest-index covering triangle. Triangle vertices and colours are loaded at run time through a valid/ready write port into shadow registers. They commit atomically at frame end, so no frame is ever drawn with a half-updated triangle. It sits directly between the 50 MHz clock and the VGA connector, as the top of the video path.

## Interface
- H_TOTAL, 1586: horizontal counter period in clocks (counter runs 0..H_TOTAL-1).
- H_SYNC, 190: HS low while cx < H_SYNC.
- H_START / H_END, 285 / 1555: visible when H_START <= cx < H_END.
- V_TOTAL, 526: lines per frame (cy 0..V_TOTAL-1).
- V_SYNC, 2: VS low while cy < V_SYNC.
- V_START / V_END, 35 / 515: visible line range.
- NUM_TRI, 4: triangle slots (1..8).
- COORD_W, 12: signed vertex/counter coordinate width.
- BG, 12'h000: background RGB (4:4:4) inside the visible area.
- TWO_SIDED, 0: 0 = inside only if all edge values <= 0; 1 = also inside if all >= 0.
- CLOCK_50 in 1: single clock.
- RST in 1: synchronous, active-high reset.
- wr_valid in 1: write request.
- wr_ready out 1: write accepted when wr_valid && wr_ready.
- wr_idx in $clog2(NUM_TRI): triangle slot.
- wr_field in 2: 0/1/2 = vertex P1/P2/P3 (uses wr_x, wr_y); 3 = colour/enable (uses wr_color, wr_en).
- wr_x, wr_y in COORD_W: signed vertex coordinates in counter units.
- wr_color in 12: RGB 4:4:4.
- wr_en in 1: slot enable.
- frame_start out 1: one-cycle pulse on the commit cycle.
- VGA_R, VGA_G, VGA_B out 4: colour, 0 outside the visible area.
- VGA_HS, VGA_VS out 1: sync, active low.

## Operation
- Counters:
  - cx increments every clock; at H_TOTAL-1 it wraps to 0 and cy increments.
  - cy wraps to 0 after V_TOTAL-1.
- Commit cycle: cx == H_TOTAL-1 && cy == V_TOTAL-1.
  - The shadow bank copies into the active bank.
  - frame_start = 1.
  - wr_ready = 0 (this is the only cycle ready is low). A request pending on that cycle is held by the master and accepted on the next cycle, landing in the next frame's shadow.
- Writes touch only the shadow bank. Each accepted write updates only the addressed field. Writes with wr_idx >= NUM_TRI are accepted and discarded.
- Edge function for edge a→b:
  - E = (bx-ax)*(cy-ay) - (cx-ax)*(by-ay).
  - Differences are computed at COORD_W+1 bits and products at 2*COORD_W+3 bits, all signed, with no truncation.
- Coverage and colour:
  - A triangle is inside when enabled and the sign test per TWO_SIDED passes. Degenerate (zero-area) triangles are covered only on the pixels where all E == 0.
  - Pixel colour: visible ? (any inside ? color of lowest inside index : BG) : 0.
- Reset:
  - cx = cy = 0; all pipeline registers cleared.
  - Active and shadow banks: all slots disabled, coordinates 0, colour 0.
  - Outputs: RGB = 0, HS = 0, VS = 0, wr_ready = 1, frame_start = 0.
  - Reset asserted mid-frame or mid-write discards both banks. Reset has priority over commit and write in the same cycle.

## Timing
- Pipeline latency is 2 cycles from counter value to pins:
  - Stage 1 registers coordinate differences and the visible/sync flags.
  - Stage 2 registers products, sign decision, priority select and RGB.
- HS, VS and visible are delayed by the same 2 stages, so RGB and sync stay mutually aligned. Example: the sync change for cx == H_SYNC appears on VGA_HS 2 cycles later.
- A write accepted in cycle t is visible from the first pixel of the frame after the next commit, never earlier.
- After reset release, the first valid outputs appear 2 cycles later; HS and VS stay 0 until then.

## Structure
- Shared package vga_pkg holds:
  - the default 4:4:4 colour typedef;
  - the default timing constants (1586/190/285/1555, 526/2/35/515);
  - the wr_field encodings FLD_P1 = 0, FLD_P2 = 1, FLD_P3 = 2, FLD_COL = 3.
- One sub-module, vga_timing: cx/cy counters, commit strobe, raw HS/VS/visible, all timing parameters. The rasteriser instantiates it and generates one edge-evaluation lane per triangle.

## Test plan
- Reset then free-run, defaults: HS period 1586 clocks with 190 low; VS low for exactly 2 × 1586 clocks; RGB == 0 at every pixel (no slots enabled, BG = 0).
- Load slot 0 with P1 = (300,100), P2 = (400,300), P3 = (600,200), colour 12'hCCC, enabled: pixel (400,200) → CCC and (300,300) → 000, both appearing 2 cycles after the counter value; the triangle is drawn in the frame after the commit, not the current frame.
- Overlap: slot 0 = red 12'hF00 and slot 2 = blue 12'h00F over the same region → red; disable slot 0 → blue from the next frame.
- Write held on the commit cycle: wr_ready = 0 for exactly that cycle; the write completes on the next cycle; a mid-frame vertex edit never tears (every pixel of a frame matches a single bank).
- TWO_SIDED = 0 with the reversed winding P1 = (600,200), P3 = (300,100) → not drawn; TWO_SIDED = 1 → drawn.
- Assert RST mid-frame with slots enabled: the next cycle has cx = cy = 0; after release, output stays black until new writes plus a commit.
